// File: rtl/usart_tx_queue.sv
// Bus-write capture queue feeding usart_ctrl: synchronises the bus strobe, buffers
// written bytes in a circular FIFO and issues them one at a time under a busy handshake.
module usart_tx_queue #(
    parameter int BITWIDTH    = 6,
    parameter int DEPTH       = 8,
    parameter int CMD_SEND    = 2,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       addr_strobe,
    input  logic                       read_write,
    input  logic [BITWIDTH-1:0]        bus_data,
    input  logic                       usart_busy,
    input  logic                       clear_overflow,
    output logic                       usart_write,
    output logic [2:0]                 usart_cmd,
    output logic [7:0]                 usart_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state, next_state;
    logic [TW-1:0]   ack_cnt;
    logic            strobe_s1, strobe_s2, strobe_prev;
    logic            rw_s1, rw_s2;
    logic            push_req, push_ok, pop;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    // Idle-high reset values keep a falling edge from appearing right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_s1   <= 1'b1;
            strobe_s2   <= 1'b1;
            strobe_prev <= 1'b1;
            rw_s1       <= 1'b1;
            rw_s2       <= 1'b1;
        end else begin
            strobe_s1   <= addr_strobe;
            strobe_s2   <= strobe_s1;
            strobe_prev <= strobe_s2;
            rw_s1       <= read_write;
            rw_s2       <= rw_s1;
        end
    end

    assign push_req   = !strobe_s2 && strobe_prev && !rw_s2;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= 8'(bus_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE:     next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (usart_busy)                        next_state = WAIT_DONE;
                else if (ack_cnt == TW'(ACK_TIMEOUT))  next_state = IDLE;
            end
            WAIT_DONE: begin
                if (!usart_busy) next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ack_cnt     <= '0;
            usart_write <= 1'b0;
            usart_cmd   <= '0;
            usart_data  <= '0;
        end else begin
            state       <= next_state;
            usart_write <= (next_state == ISSUE);
            if (pop) begin
                usart_data <= mem[rd_ptr];
                usart_cmd  <= 3'(CMD_SEND);
            end
            if (state == ISSUE)
                ack_cnt <= '0;
            else if (state == WAIT_ACK && next_state == WAIT_ACK)
                ack_cnt <= ack_cnt + 1'b1;
        end
    end

endmodule
